plat_land_scan: RTL and testbench

- Consumer of the per-block platform table (relative x, relative y and length per platform) produced by the level generator.
- On request, sequentially scans all platforms of the current block against one player move step and reports the platform the player lands on: index and surface y.
- Sits between the physics unit (requester) and the block table; one platform is evaluated per cycle to keep comparator count at one.

---
 rtl/plat_land_scan.sv | 207 ++++++++++++++++++++
 tb/tb_plat_land_scan.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/plat_land_scan.sv
// rtl/plat_land_scan.sv - sequential landing scan of one block's platform table (optional PLAT_CEIL_BUMP_EN)
module plat_land_scan #(
    parameter int PLATFORM_NUM_PER_BLOCK = 7,
    parameter int PHY_WIDTH              = 16,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int TILE_WIDTH             = 8,
    parameter int PLAYER_WIDTH           = 16,
    parameter int IDX_WIDTH              = 3
`ifdef PLAT_CEIL_BUMP_EN
    ,
    parameter int PLAT_THICK             = 8
`endif
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst_n,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    input  logic                                          block_switch,
    input  logic                                          start,
    input  logic [PHY_WIDTH-1:0]                          player_x,
    input  logic [PHY_WIDTH-1:0]                          prev_foot_y,
    input  logic [PHY_WIDTH-1:0]                          next_foot_y,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          hit,
    output logic                                          aborted,
    output logic [IDX_WIDTH-1:0]                          hit_idx,
    output logic [PHY_WIDTH-1:0]                          land_y
`ifdef PLAT_CEIL_BUMP_EN
    ,
    output logic                                          hit_ceil
`endif
);

    localparam int SLOTS = 1 << IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PLATFORM_NUM_PER_BLOCK - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t state_q, state_d;

    // Table padded to a power of two so the scan index never selects past the array.
    logic [SLOTS*PHY_WIDTH-1:0]       x_pad, y_pad;
    logic [SLOTS*BLOCK_LEN_WIDTH-1:0] len_pad;

    assign x_pad   = (SLOTS*PHY_WIDTH)'(plat_relative_x);
    assign y_pad   = (SLOTS*PHY_WIDTH)'(plat_relative_y);
    assign len_pad = (SLOTS*BLOCK_LEN_WIDTH)'(plat_len);

    logic [PHY_WIDTH-1:0]       snap_x   [SLOTS];
    logic [PHY_WIDTH-1:0]       snap_y   [SLOTS];
    logic [BLOCK_LEN_WIDTH-1:0] snap_len [SLOTS];
    logic [PHY_WIDTH-1:0]       p_x, p_prev, p_next;
    logic [IDX_WIDTH-1:0]       idx_q;
    logic                       best_v;
    logic [PHY_WIDTH-1:0]       best_y;
    logic [IDX_WIDTH-1:0]       best_idx;
    logic                       abort_q;
`ifdef PLAT_CEIL_BUMP_EN
    logic                       best_ceil;
`endif

    logic [PHY_WIDTH-1:0]       cur_x, cur_y;
    logic [BLOCK_LEN_WIDTH-1:0] cur_len;
    logic [PHY_WIDTH:0]         x_end, p_right;
    logic                       x_ovl, land_match, land_better, upd;

    always_comb begin
        cur_x       = snap_x[idx_q];
        cur_y       = snap_y[idx_q];
        cur_len     = snap_len[idx_q];
        // One extra bit keeps the right edges from wrapping near the top of the coordinate range.
        x_end       = {1'b0, cur_x}
                    + (PHY_WIDTH+1)'(cur_len) * (PHY_WIDTH+1)'(TILE_WIDTH)
                    - (PHY_WIDTH+1)'(1);
        p_right     = {1'b0, p_x} + (PHY_WIDTH+1)'(PLAYER_WIDTH - 1);
        x_ovl       = (cur_len != '0) && (p_right >= {1'b0, cur_x}) && ({1'b0, p_x} <= x_end);
        land_match  = x_ovl && (p_prev > p_next) && (p_prev >= cur_y) && (p_next <= cur_y);
        land_better = land_match && (!best_v || (cur_y > best_y));
    end

`ifdef PLAT_CEIL_BUMP_EN
    logic [PHY_WIDTH+1:0] head_prev, head_next, y_ext;
    logic                 ceil_match, ceil_better;

    // Head-vs-underside test rearranged as head + thickness against Y to avoid subtracting.
    always_comb begin
        head_prev   = {2'b00, p_prev} + (PHY_WIDTH+2)'(PLAYER_WIDTH + PLAT_THICK);
        head_next   = {2'b00, p_next} + (PHY_WIDTH+2)'(PLAYER_WIDTH + PLAT_THICK);
        y_ext       = {2'b00, cur_y};
        ceil_match  = x_ovl && (p_next > p_prev) && (cur_y >= PHY_WIDTH'(PLAT_THICK))
                    && (head_prev <= y_ext) && (head_next >= y_ext);
        ceil_better = ceil_match && (!best_v || (cur_y < best_y));
        upd         = land_better || ceil_better;
    end
`else
    assign upd = land_better;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (block_switch || (idx_q == LAST_IDX)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                snap_x[i]   <= '0;
                snap_y[i]   <= '0;
                snap_len[i] <= '0;
            end
            p_x      <= '0;
            p_prev   <= '0;
            p_next   <= '0;
            idx_q    <= '0;
            best_v   <= 1'b0;
            best_y   <= '0;
            best_idx <= '0;
            abort_q  <= 1'b0;
            done     <= 1'b0;
            hit      <= 1'b0;
            aborted  <= 1'b0;
            hit_idx  <= '0;
            land_y   <= '0;
`ifdef PLAT_CEIL_BUMP_EN
            best_ceil <= 1'b0;
            hit_ceil  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            snap_x[i]   <= x_pad[i*PHY_WIDTH +: PHY_WIDTH];
                            snap_y[i]   <= y_pad[i*PHY_WIDTH +: PHY_WIDTH];
                            snap_len[i] <= len_pad[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
                        end
                        p_x      <= player_x;
                        p_prev   <= prev_foot_y;
                        p_next   <= next_foot_y;
                        idx_q    <= '0;
                        best_v   <= 1'b0;
                        best_y   <= '0;
                        best_idx <= '0;
                        abort_q  <= 1'b0;
                        hit      <= 1'b0;
                        aborted  <= 1'b0;
                        hit_idx  <= '0;
                        land_y   <= '0;
`ifdef PLAT_CEIL_BUMP_EN
                        best_ceil <= 1'b0;
                        hit_ceil  <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (block_switch) begin
                        abort_q <= 1'b1;
                    end else begin
                        if (upd) begin
                            best_v   <= 1'b1;
                            best_y   <= cur_y;
                            best_idx <= idx_q;
`ifdef PLAT_CEIL_BUMP_EN
                            best_ceil <= ceil_better;
`endif
                        end
                        idx_q <= idx_q + IDX_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    aborted <= abort_q;
                    if (!abort_q && best_v) begin
                        hit     <= 1'b1;
                        hit_idx <= best_idx;
`ifdef PLAT_CEIL_BUMP_EN
                        hit_ceil <= best_ceil;
                        land_y   <= best_ceil ? (best_y - PHY_WIDTH'(PLAT_THICK)) : best_y;
`else
                        land_y  <= best_y;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_plat_land_scan.sv
// tb/tb_plat_land_scan.sv - directed vector bench for plat_land_scan
module tb_plat_land_scan;

    logic               sys_clk;
    logic               sys_rst_n;
    logic [6:0][15:0]   plat_relative_x;
    logic [6:0][15:0]   plat_relative_y;
    logic [6:0][3:0]    plat_len;
    logic               block_switch;
    logic               start;
    logic [15:0]        player_x, prev_foot_y, next_foot_y;
    logic               busy, done, hit, aborted;
    logic [2:0]         hit_idx;
    logic [15:0]        land_y;
`ifdef PLAT_CEIL_BUMP_EN
    logic               hit_ceil;
`endif

    plat_land_scan dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .plat_relative_x (plat_relative_x),
        .plat_relative_y (plat_relative_y),
        .plat_len        (plat_len),
        .block_switch    (block_switch),
        .start           (start),
        .player_x        (player_x),
        .prev_foot_y     (prev_foot_y),
        .next_foot_y     (next_foot_y),
        .busy            (busy),
        .done            (done),
        .hit             (hit),
        .aborted         (aborted),
        .hit_idx         (hit_idx),
        .land_y          (land_y)
`ifdef PLAT_CEIL_BUMP_EN
        ,
        .hit_ceil        (hit_ceil)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [6:0][15:0] tx;
        logic [6:0][15:0] ty;
        logic [6:0][3:0]  tl;
        logic [15:0]      px;
        logic [15:0]      prev;
        logic [15:0]      nxt;
        logic             e_hit;
        logic [2:0]       e_idx;
        logic [15:0]      e_y;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];
    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        plat_relative_x = v.tx;
        plat_relative_y = v.ty;
        plat_len        = v.tl;
        player_x        = v.px;
        prev_foot_y     = v.prev;
        next_foot_y     = v.nxt;
    endtask

    task automatic run_scan(input vec_t v, output int lat);
        lat = -1;
        @(negedge sys_clk);
        load(v);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge sys_clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    vec_t v;
    int   lat;
    int   extra;

    initial begin
        total = 0;
        bad   = 0;
        sys_rst_n = 1'b0;
        start = 1'b0;
        block_switch = 1'b0;
        v = '0;
        load(v);

        // Vector table
        v = '0; v.tx[1] = 100; v.ty[1] = 100; v.tl[1] = 8;
        v.px = 100; v.prev = 110; v.nxt = 95; v.e_hit = 1; v.e_idx = 1; v.e_y = 100;
        vecs[0] = v;
        v = '0; v.tx[2] = 50; v.ty[2] = 80; v.tl[2] = 10; v.tx[4] = 60; v.ty[4] = 90; v.tl[4] = 10;
        v.px = 70; v.prev = 120; v.nxt = 70; v.e_hit = 1; v.e_idx = 4; v.e_y = 90;
        vecs[1] = v;
        v.ty[2] = 90; v.e_idx = 2;
        vecs[2] = v;
        v = '0; v.tx[0] = 200; v.ty[0] = 50; v.tl[0] = 2; v.prev = 60; v.nxt = 40;
        v.px = 184; vecs[3] = v;
        v.px = 185; v.e_hit = 1; v.e_y = 50; vecs[4] = v;
        v.px = 215; vecs[5] = v;
        v.px = 216; v.e_hit = 0; v.e_y = 0; vecs[6] = v;
        v.px = 200; v.prev = 40; v.nxt = 60; vecs[7] = v;
        v.prev = 50; v.nxt = 50; vecs[8] = v;
        v.prev = 60; v.nxt = 50; v.e_hit = 1; v.e_y = 50; vecs[9] = v;
        v = '0; v.tx[3] = 100; v.ty[3] = 100; v.tl[3] = 0;
        v.px = 100; v.prev = 110; v.nxt = 95;
        vecs[10] = v;

        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_aborted", aborted, 0);
        check("rst_hit_idx", hit_idx, 0);
        check("rst_land_y", land_y, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_scan(vecs[i], lat);
            check($sformatf("v%0d_latency", i), lat, 8);
            check($sformatf("v%0d_hit", i), hit, vecs[i].e_hit);
            check($sformatf("v%0d_hit_idx", i), hit_idx, vecs[i].e_idx);
            check($sformatf("v%0d_land_y", i), land_y, vecs[i].e_y);
            check($sformatf("v%0d_aborted", i), aborted, 0);
            @(posedge sys_clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_hold_hit", i), hit, vecs[i].e_hit);
            check($sformatf("v%0d_busy_after", i), busy, 0);
        end

`ifdef PLAT_CEIL_BUMP_EN
        v = '0; v.tx[0] = 200; v.ty[0] = 50; v.tl[0] = 2; v.px = 200; v.prev = 20; v.nxt = 30;
        run_scan(v, lat);
        check("ceil_latency", lat, 8);
        check("ceil_hit", hit, 1);
        check("ceil_hit_ceil", hit_ceil, 1);
        check("ceil_land_y", land_y, 42);
        run_scan(vecs[0], lat);
        check("land_hit_ceil", hit_ceil, 0);
`endif

        // Abort by block_switch, with a second start ignored while busy
        @(negedge sys_clk);
        load(vecs[0]);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        @(posedge sys_clk);
        #1;
        check("abort_busy", busy, 1);
        @(negedge sys_clk);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        @(negedge sys_clk);
        block_switch = 1'b1;
        @(posedge sys_clk);
        #1 block_switch = 1'b0;
        @(posedge sys_clk);
        #1;
        check("abort_done", done, 1);
        check("abort_hit", hit, 0);
        check("abort_aborted", aborted, 1);
        check("abort_land_y", land_y, 0);
        check("abort_busy_fall", busy, 0);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge sys_clk);
            #1;
            if (done || busy) extra++;
        end
        check("abort_ignored_start", extra, 0);

        // block_switch while idle has no effect
        @(negedge sys_clk);
        block_switch = 1'b1;
        @(negedge sys_clk);
        block_switch = 1'b0;
        run_scan(vecs[0], lat);
        check("idle_bs_latency", lat, 8);
        check("idle_bs_hit", hit, 1);
        check("idle_bs_aborted", aborted, 0);

        // Reset in the middle of a scan
        @(negedge sys_clk);
        load(vecs[0]);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        check("midrst_busy_before", busy, 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hit", hit, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_scan(vecs[1], lat);
        check("postrst_latency", lat, 8);
        check("postrst_hit", hit, 1);
        check("postrst_hit_idx", hit_idx, 4);
        check("postrst_land_y", land_y, 90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
